// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: instruction width and the bubble encoding.
`ifndef FETCH_UNIT_DEFINES
`define FETCH_UNIT_DEFINES
`define NOP_INSTR 32'h0000_0013
`define INSTR_BITS 32
`endif

package fetch_unit_pkg;

   localparam int unsigned INSTR_W = `INSTR_BITS;
   localparam logic [INSTR_W-1:0] NOP_INSTR = `NOP_INSTR;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with push/pop/flush; used for the in-flight PC queue and the decode buffer.
module fetch_fifo #(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned WIDTH = 32,
   localparam int unsigned CW = $clog2(DEPTH + 1)
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_push_data,
   input  logic             i_pop,
   input  logic             i_flush,
   output logic [WIDTH-1:0] o_head,
   output logic             o_empty,
   output logic             o_full,
   output logic [CW-1:0]    o_count
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]    r_rdPtr;
   logic [PW-1:0]    r_wrPtr;
   logic [CW-1:0]    r_count;
   logic             w_doPush;
   logic             w_doPop;

   function automatic logic [PW-1:0] bumpPtr(input logic [PW-1:0] ptr);
      return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
   endfunction

   assign o_empty  = (r_count == '0);
   assign o_full   = (r_count == CW'(DEPTH));
   assign o_count  = r_count;
   assign o_head   = r_mem[r_rdPtr];
   assign w_doPush = i_push & ~o_full;
   assign w_doPop  = i_pop & ~o_empty;

   // Flush wins over any same-cycle push or pop.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n || i_flush) begin
         r_rdPtr <= '0;
         r_wrPtr <= '0;
         r_count <= '0;
      end else begin
         if (w_doPush) begin
            r_mem[r_wrPtr] <= i_push_data;
            r_wrPtr        <= bumpPtr(r_wrPtr);
         end
         if (w_doPop) begin
            r_rdPtr <= bumpPtr(r_rdPtr);
         end
         case ({w_doPush, w_doPop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues credit-limited in-order fetches and buffers
// returned instructions for decode, honouring stall and branch redirect from later stages.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int unsigned      XLEN       = 32,
   parameter logic [XLEN-1:0]  RESET_PC   = '0,
   parameter int unsigned      FIFO_DEPTH = 2
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_stall_fetch,
   input  logic               i_took_branch,
   input  logic [XLEN-1:0]    i_branch_target,
   output logic               o_imem_req_valid,
   input  logic               i_imem_req_ready,
   output logic [XLEN-1:0]    o_imem_req_addr,
   input  logic               i_imem_resp_valid,
   input  logic [INSTR_W-1:0] i_imem_resp_data,
   output logic               o_valid_dec,
   output logic [INSTR_W-1:0] o_instr_dec,
   output logic [XLEN-1:0]    o_pc_dec
);

   localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned DW = XLEN + INSTR_W;

   logic [XLEN-1:0] r_pc;
   logic [CW-1:0]   r_outstanding;
   logic [CW-1:0]   r_dropCnt;

   logic            w_credit;
   logic            w_fire;
   logic            w_respLive;
   logic            w_dropResp;
   logic            w_push;
   logic            w_pop;
   logic [XLEN-1:0] w_respPc;
   logic [DW-1:0]   w_decHead;
   logic            w_decEmpty;
   logic            w_decFull;
   logic [CW-1:0]   w_decCount;
   logic            w_pcqEmpty;
   logic            w_pcqFull;
   logic [CW-1:0]   w_pcqCount;

   // Credit counts every slot already promised: requests in flight plus buffered entries.
   assign w_credit         = (32'(r_outstanding) + 32'(w_decCount)) < FIFO_DEPTH;
   assign o_imem_req_valid = i_rst_n & ~i_took_branch & w_credit;
   assign o_imem_req_addr  = r_pc;
   assign w_fire           = o_imem_req_valid & i_imem_req_ready;

   assign w_respLive = i_imem_resp_valid & (r_outstanding != '0);
   assign w_dropResp = w_respLive & (i_took_branch | (r_dropCnt != '0));
   assign w_push     = w_respLive & ~w_dropResp;
   assign w_pop      = o_valid_dec & ~i_stall_fetch & ~i_took_branch;

   assign o_valid_dec = ~w_decEmpty;
   assign o_instr_dec = o_valid_dec ? w_decHead[INSTR_W-1:0] : NOP_INSTR;
   assign o_pc_dec    = o_valid_dec ? w_decHead[DW-1:INSTR_W] : '0;

   // On redirect every response still in flight belongs to the squashed stream, so the
   // drop count becomes the post-cycle outstanding count rather than accumulating.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_pc          <= RESET_PC;
         r_outstanding <= '0;
         r_dropCnt     <= '0;
      end else begin
         if (i_took_branch) begin
            r_pc <= i_branch_target;
         end else if (w_fire) begin
            r_pc <= r_pc + XLEN'(4);
         end
         r_outstanding <= r_outstanding + CW'(w_fire) - CW'(w_respLive);
         if (i_took_branch) begin
            r_dropCnt <= r_outstanding - CW'(w_respLive);
         end else if (w_respLive && (r_dropCnt != '0)) begin
            r_dropCnt <= r_dropCnt - 1'b1;
         end
      end
   end

   fetch_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(XLEN)) u_pcQueue (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_push      (w_fire),
      .i_push_data (r_pc),
      .i_pop       (w_respLive),
      .i_flush     (1'b0),
      .o_head      (w_respPc),
      .o_empty     (w_pcqEmpty),
      .o_full      (w_pcqFull),
      .o_count     (w_pcqCount)
   );

   fetch_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DW)) u_decBuffer (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_push      (w_push),
      .i_push_data ({w_respPc, i_imem_resp_data}),
      .i_pop       (w_pop),
      .i_flush     (i_took_branch),
      .o_head      (w_decHead),
      .o_empty     (w_decEmpty),
      .o_full      (w_decFull),
      .o_count     (w_decCount)
   );

   respNeedsOutstanding: assert property (@(posedge i_clk) disable iff (!i_rst_n)
      i_imem_resp_valid |-> (r_outstanding != '0) && !w_pcqEmpty);
   noPushWhenFull: assert property (@(posedge i_clk) disable iff (!i_rst_n)
      !(w_push && w_decFull));
   noIssueWhenPcqFull: assert property (@(posedge i_clk) disable iff (!i_rst_n)
      !(w_fire && w_pcqFull));
   pcqTracksOutstanding: assert property (@(posedge i_clk) disable iff (!i_rst_n)
      w_pcqCount == r_outstanding);

endmodule
